// File: rtl/osd_dp_trace_fifo.sv
// Trace event FIFO between the CPU core and the debug processor trace input.
// Dropped events are counted and reported in-band as a single overflow marker event.
module osd_dp_trace_fifo #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CNT_WIDTH = 16,
   parameter logic [15:0] OVF_ID    = 16'hFFFF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     core_trace_valid,
   input  logic [15:0]              core_trace_id,
   input  logic [XLEN-1:0]          core_trace_value,
   output logic                     trace_valid,
   output logic [15:0]              trace_id,
   output logic [XLEN-1:0]          trace_value,
   input  logic                     trace_ready,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     ovf_pending
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned SW = CNT_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [15:0]          mem_id    [DEPTH];
   logic [XLEN-1:0]      mem_value [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CNT_WIDTH-1:0] cnt;

   logic                 pop;
   logic                 space;
   logic                 in_evt;
   logic                 wr_en;
   logic [15:0]          wr_id;
   logic [XLEN-1:0]      wr_value;
   logic [SW-1:0]        cnt_sum;
   logic [CNT_WIDTH-1:0] cnt_sat;
   logic [CNT_WIDTH-1:0] cnt_next;

   // First-word-fall-through head straight from storage
   assign trace_valid = (fill_level != '0);
   assign trace_id    = mem_id[rd_ptr[AW-1:0]];
   assign trace_value = mem_value[rd_ptr[AW-1:0]];

   assign pop    = trace_valid && trace_ready;
   assign space  = (fill_level < PW'(DEPTH)) || pop;
   assign in_evt = core_trace_valid && enable;

   // Write decision: a pending marker wins over the core event, which is then folded into its count
   always_comb begin
      wr_en    = 1'b0;
      wr_id    = core_trace_id;
      wr_value = core_trace_value;
      cnt_next = cnt;
      cnt_sum  = {1'b0, cnt} + SW'(in_evt);
      cnt_sat  = cnt_sum[CNT_WIDTH] ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
      if ((cnt != '0) && space) begin
         wr_en    = 1'b1;
         wr_id    = OVF_ID;
         wr_value = XLEN'(cnt_sat);
         cnt_next = '0;
      end else if (in_evt && space) begin
         wr_en = 1'b1;
      end else if (in_evt) begin
         cnt_next = cnt_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_level  <= '0;
         cnt         <= '0;
         ovf_pending <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         case ({wr_en, pop})
            2'b10:   fill_level <= fill_level + PW'(1);
            2'b01:   fill_level <= fill_level - PW'(1);
            default: fill_level <= fill_level;
         endcase
         cnt         <= cnt_next;
         ovf_pending <= (cnt_next != '0);
      end
   end

   // Storage carries no reset; contents are only observed through valid entries
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_id[wr_ptr[AW-1:0]]    <= wr_id;
         mem_value[wr_ptr[AW-1:0]] <= wr_value;
      end
   end

endmodule

// File: tb/tb_osd_dp_trace_fifo.sv
// Directed self-checking bench for osd_dp_trace_fifo; a second instance uses a 4-bit drop counter.
module tb_osd_dp_trace_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        core_trace_valid;
   logic [15:0] core_trace_id;
   logic [63:0] core_trace_value;
   logic        trace_valid;
   logic [15:0] trace_id;
   logic [63:0] trace_value;
   logic        trace_ready;
   logic [3:0]  fill_level;
   logic        ovf_pending;

   logic        b_core_trace_valid;
   logic [15:0] b_core_trace_id;
   logic [63:0] b_core_trace_value;
   logic        b_trace_valid;
   logic [15:0] b_trace_id;
   logic [63:0] b_trace_value;
   logic        b_trace_ready;
   logic [3:0]  b_fill_level;
   logic        b_ovf_pending;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   osd_dp_trace_fifo dut (
      .clk(clk), .rst(rst), .enable(enable),
      .core_trace_valid(core_trace_valid), .core_trace_id(core_trace_id),
      .core_trace_value(core_trace_value),
      .trace_valid(trace_valid), .trace_id(trace_id), .trace_value(trace_value),
      .trace_ready(trace_ready), .fill_level(fill_level), .ovf_pending(ovf_pending)
   );

   osd_dp_trace_fifo #(.CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst), .enable(enable),
      .core_trace_valid(b_core_trace_valid), .core_trace_id(b_core_trace_id),
      .core_trace_value(b_core_trace_value),
      .trace_valid(b_trace_valid), .trace_id(b_trace_id), .trace_value(b_trace_value),
      .trace_ready(b_trace_ready), .fill_level(b_fill_level), .ovf_pending(b_ovf_pending)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [15:0] id, input logic [63:0] val);
      core_trace_valid = v;
      core_trace_id    = id;
      core_trace_value = val;
   endtask

   initial begin
      rst = 1'b0; enable = 1'b1; trace_ready = 1'b0;
      drv(1'b0, 16'h0, 64'h0);
      b_core_trace_valid = 1'b0; b_core_trace_id = 16'h0; b_core_trace_value = 64'h0;
      b_trace_ready = 1'b0;
      tick(); tick();
      rst = 1'b1;
      check("rst_valid", 64'(trace_valid), 64'd0);
      check("rst_fill", 64'(fill_level), 64'd0);
      check("rst_ovf", 64'(ovf_pending), 64'd0);

      // Ready while empty does nothing
      trace_ready = 1'b1;
      tick();
      check("empty_ready_fill", 64'(fill_level), 64'd0);

      // 1: pass-through, one cycle latency each
      drv(1'b1, 16'd1, 64'd10); tick();
      check("t1_id1", 64'(trace_id), 64'd1);
      check("t1_val1", trace_value, 64'd10);
      drv(1'b1, 16'd2, 64'd20); tick();
      check("t1_id2", 64'(trace_id), 64'd2);
      check("t1_val2", trace_value, 64'd20);
      check("t1_fill_mid", 64'(fill_level), 64'd1);
      drv(1'b1, 16'd3, 64'd30); tick();
      check("t1_id3", 64'(trace_id), 64'd3);
      check("t1_val3", trace_value, 64'd30);
      drv(1'b0, 16'd0, 64'd0); tick();
      check("t1_empty", 64'(trace_valid), 64'd0);
      check("t1_fill0", 64'(fill_level), 64'd0);

      // 2: eleven events into eight slots, three dropped
      trace_ready = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         drv(1'b1, 16'(i), 64'(i * 100)); tick();
      end
      drv(1'b0, 16'd0, 64'd0);
      check("t2_fill8", 64'(fill_level), 64'd8);
      check("t2_ovf", 64'(ovf_pending), 64'd1);
      trace_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("t2_pop_id", 64'(trace_id), 64'(i));
         check("t2_pop_val", trace_value, 64'(i * 100));
         tick();
         if (i == 1) check("t2_ovf_clr", 64'(ovf_pending), 64'd0);
      end
      check("t2_mark_id", 64'(trace_id), 64'hFFFF);
      check("t2_mark_val", trace_value, 64'd3);
      tick();
      check("t2_empty", 64'(trace_valid), 64'd0);

      // 3: full with two dropped, event and pop together
      trace_ready = 1'b0;
      for (int i = 21; i <= 30; i++) begin
         drv(1'b1, 16'(i), 64'(i)); tick();
      end
      check("t3_ovf", 64'(ovf_pending), 64'd1);
      drv(1'b1, 16'd31, 64'd31); trace_ready = 1'b1; tick();
      drv(1'b0, 16'd0, 64'd0);
      check("t3_fill8", 64'(fill_level), 64'd8);
      check("t3_ovf_clr", 64'(ovf_pending), 64'd0);
      for (int i = 22; i <= 28; i++) begin
         check("t3_pop_id", 64'(trace_id), 64'(i));
         tick();
      end
      check("t3_mark_id", 64'(trace_id), 64'hFFFF);
      check("t3_mark_val", trace_value, 64'd3);
      tick();
      check("t3_empty", 64'(trace_valid), 64'd0);

      // 4: 4-bit counter saturates at 15
      for (int i = 0; i < 28; i++) begin
         b_core_trace_valid = 1'b1; b_core_trace_id = 16'(40 + i); b_core_trace_value = 64'(i);
         tick();
      end
      b_core_trace_valid = 1'b0;
      check("t4_fill8", 64'(b_fill_level), 64'd8);
      check("t4_ovf", 64'(b_ovf_pending), 64'd1);
      b_trace_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("t4_mark_id", 64'(b_trace_id), 64'hFFFF);
      check("t4_mark_val", b_trace_value, 64'd15);
      tick();
      check("t4_empty", 64'(b_trace_valid), 64'd0);

      // 5: disabled capture while full drops nothing
      trace_ready = 1'b0;
      for (int i = 51; i <= 58; i++) begin
         drv(1'b1, 16'(i), 64'(i)); tick();
      end
      enable = 1'b0;
      for (int i = 60; i < 65; i++) begin
         drv(1'b1, 16'(i), 64'(i)); tick();
      end
      drv(1'b0, 16'd0, 64'd0);
      check("t5_fill8", 64'(fill_level), 64'd8);
      check("t5_ovf", 64'(ovf_pending), 64'd0);
      enable = 1'b1; trace_ready = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("t5_last_id", 64'(trace_id), 64'd58);
      tick();
      check("t5_no_mark", 64'(trace_valid), 64'd0);

      // 6: reset mid-operation discards entries and pending count
      trace_ready = 1'b0;
      for (int i = 71; i <= 79; i++) begin
         drv(1'b1, 16'(i), 64'(i)); tick();
      end
      drv(1'b0, 16'd0, 64'd0);
      check("t6_pre_ovf", 64'(ovf_pending), 64'd1);
      rst = 1'b0; tick(); rst = 1'b1;
      check("t6_valid", 64'(trace_valid), 64'd0);
      check("t6_fill", 64'(fill_level), 64'd0);
      check("t6_ovf", 64'(ovf_pending), 64'd0);
      drv(1'b1, 16'h55, 64'h77); tick();
      drv(1'b0, 16'd0, 64'd0);
      check("t6_ev_valid", 64'(trace_valid), 64'd1);
      check("t6_ev_id", 64'(trace_id), 64'h55);
      check("t6_ev_val", trace_value, 64'h77);
      check("t6_ev_fill", 64'(fill_level), 64'd1);
      trace_ready = 1'b1; tick();
      check("t6_no_mark", 64'(trace_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
